mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single unified instruction/data memory of the multicycle core between two requesters.
  - Port 0: CPU fetch/load/store path.
  - Port 1: DMA/program loader.
- Round-robin arbitration, a fixed-latency access sequencer, and a one-cycle completion handshake per access.
- Sits between the requesters and the memory macro. The CPU's control FSM stalls in its memory states until its ready pulse arrives.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 2, memory access cycles per transaction; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- req  input  2  per-port request; bit0 CPU, bit1 DMA
- we  input  2  per-port write enable, qualified by req
- addr0  input  ADDR_W  CPU address
- addr1  input  ADDR_W  DMA address
- wdata0  input  DATA_W  CPU write data
- wdata1  input  DATA_W  DMA write data
- ready  output  2  one-hot, single-cycle completion pulse per port
- rdata  output  DATA_W  read data, valid in the ready cycle
- gnt  output  2  one-hot; identifies the owner during ACCESS and RESP
- busy  output  1  high in ACCESS and RESP
- mem_adr  output  ADDR_W  memory address
- mem_wd  output  DATA_W  memory write data
- mem_we  output  1  memory write strobe
- mem_rd  input  DATA_W  memory read data, valid MEM_LAT cycles after mem_adr is presented

Behaviour:
- State machine:
  - IDLE, ACCESS, RESP.
  - Reset state is IDLE.
  - The state encoding comes from the shared package.
- Reset values:
  - ready=0, gnt=0, busy=0, mem_we=0.
  - rdata=0, mem_adr=0, mem_wd=0.
  - last_grant=1, so the CPU wins the first contention.
  - cnt=0.
- IDLE:
  - req is sampled.
  - Only one bit set: grant that port.
  - Both bits set: grant the port != last_grant.
  - On grant:
    - Latch addr, wdata and we of the winner into mem_adr, mem_wd and the internal we_q.
    - Set gnt one-hot and last_grant=winner.
    - cnt=0, go to ACCESS.
  - req=0: stay in IDLE.
- ACCESS (MEM_LAT cycles):
  - mem_adr and mem_wd are held stable.
  - mem_we = we_q only when cnt==0, i.e. a single-cycle write strobe.
  - cnt increments each cycle.
  - When cnt==MEM_LAT-1:
    - If we_q==0, register mem_rd into rdata.
    - If we_q==1, hold rdata.
    - Go to RESP.
- RESP (one cycle):
  - ready[gnt]=1, rdata valid, gnt still asserted.
  - Next state is IDLE; gnt clears.
- Latency: req seen in IDLE cycle t -> ready in cycle t+1+MEM_LAT. Minimum service period is MEM_LAT+2 cycles.
- Handshake rules:
  - A requester holds req, we, addr and wdata from assertion until it sees ready. Only the values sampled at grant are used.
  - After ready in cycle t, the requester drives req low in t+1 unless it is issuing a new access.
  - A req held high is treated as a new request in the next IDLE cycle.
- Fairness: under continuous contention, grants alternate CPU, DMA, CPU, ... No port waits longer than 2*(MEM_LAT+2) cycles.
- Request changes: a req bit dropping during ACCESS or RESP of the other port has no effect; a losing request is never latched early.
- we without req: ignored.
- Reset mid-operation:
  - Any state -> IDLE on the next edge.
  - No ready is issued for the aborted access.
  - mem_we=0 from the first cycle after reset.
- Counter: cnt width 4 bits; it never wraps because MEM_LAT<=15.

Decomposition:
- Shared package (mem_arb_pkg) holds:
  - State localparams ARB_IDLE=2'd0, ARB_ACCESS=2'd1, ARB_RESP=2'd2.
  - Port index constants PORT_CPU=0, PORT_DMA=1.
- One natural sub-module, rr_sel2: combinational.
  - Inputs: req[1:0], last_grant.
  - Outputs: winner index and a valid flag.
- All other logic stays in mem_arbiter.

Test Plan:
- CPU read, MEM_LAT=2:
  - Stimulus: req=01, we=00, addr0=0x40, memory returns 0xDEADBEEF.
  - Response: ready=01 exactly 3 cycles after the IDLE sample, rdata=0xDEADBEEF, gnt=01 throughout, mem_we never high.
- DMA write:
  - Stimulus: req=10, we=10, addr1=0x100, wdata1=0x12345678.
  - Response: mem_we high for exactly one cycle with mem_adr=0x100 and mem_wd=0x12345678, then ready=10; rdata unchanged.
- Simultaneous requests held for 4 transactions:
  - Stimulus: req=11 held through 4 completed transactions.
  - Response: grant order CPU, DMA, CPU, DMA; ready alternates 01, 10, 01, 10 with a period of MEM_LAT+2 cycles.
- Late arrival:
  - Stimulus: CPU back-to-back reads; DMA raises req mid-ACCESS of the CPU's first read.
  - Response: the DMA is served next even though the CPU re-requests, and the DMA's addr1 change during the CPU access is not used.
- Reset mid-write:
  - Stimulus: reset asserted on the cnt==0 ACCESS cycle of a write.
  - Response: next cycle state=IDLE, mem_we=0, gnt=0, no ready pulse; a CPU-then-DMA contention after reset grants the CPU first.
- MEM_LAT=1 corner:
  - Stimulus: single read.
  - Response: ready 2 cycles after the sample, and the mem_rd captured at the cnt==0 cycle is returned.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory arbiter: FSM state encoding and port indices.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_sel2.sv
// Two-way round-robin selector: picks the requesting port, or the one that did not win last.
module rr_sel2
  import mem_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic       o_winner,
  output logic       o_valid
);

  always_comb begin
    o_valid  = |i_req;
    o_winner = PORT_CPU;
    case (i_req)
      2'b01:   o_winner = PORT_CPU;
      2'b10:   o_winner = PORT_DMA;
      2'b11:   o_winner = ~i_last_grant;
      default: o_winner = PORT_CPU;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory between the CPU (port 0) and DMA (port 1),
// with a fixed MEM_LAT-cycle access sequence and a one-cycle ready pulse per access.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        ready,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        gnt,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wd,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rd
);

  localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

  arb_state_t        r_state;
  arb_state_t        w_next;
  logic [3:0]        r_cnt;
  logic              r_last;
  logic              r_we_q;
  logic [1:0]        r_ready;
  logic [1:0]        r_gnt;
  logic [DATA_W-1:0] r_rdata;
  logic [ADDR_W-1:0] r_mem_adr;
  logic [DATA_W-1:0] r_mem_wd;
  logic              w_winner;
  logic              w_valid;

  rr_sel2 u_sel (
    .i_req        (req),
    .i_last_grant (r_last),
    .o_winner     (w_winner),
    .o_valid      (w_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ARB_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ARB_IDLE:   if (w_valid) w_next = ARB_ACCESS;
      ARB_ACCESS: if (r_cnt == LAST_CNT) w_next = ARB_RESP;
      ARB_RESP:   w_next = ARB_IDLE;
      default:    w_next = ARB_IDLE;
    endcase
  end

  // Requests are only looked at in IDLE, so a loser is never latched early.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_last    <= PORT_DMA;
      r_we_q    <= 1'b0;
      r_ready   <= '0;
      r_gnt     <= '0;
      r_rdata   <= '0;
      r_mem_adr <= '0;
      r_mem_wd  <= '0;
    end else begin
      r_ready <= '0;
      case (r_state)
        ARB_IDLE: begin
          if (w_valid) begin
            r_mem_adr <= (w_winner == PORT_DMA) ? addr1  : addr0;
            r_mem_wd  <= (w_winner == PORT_DMA) ? wdata1 : wdata0;
            r_we_q    <= we[w_winner];
            r_gnt     <= (w_winner == PORT_DMA) ? 2'b10 : 2'b01;
            r_last    <= w_winner;
            r_cnt     <= '0;
          end
        end
        ARB_ACCESS: begin
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == LAST_CNT) begin
            if (!r_we_q) r_rdata <= mem_rd;
            r_ready <= r_gnt;
          end
        end
        ARB_RESP: r_gnt <= '0;
        default: ;
      endcase
    end
  end

  assign ready   = r_ready;
  assign rdata   = r_rdata;
  assign gnt     = r_gnt;
  assign busy    = (r_state != ARB_IDLE);
  assign mem_adr = r_mem_adr;
  assign mem_wd  = r_mem_wd;
  assign mem_we  = (r_state == ARB_ACCESS) && (r_cnt == '0) && r_we_q;

endmodule
